control_bird_movement: RTL and testbench

//  Vertical motion controller for the player "bird" on the 8x8 LED matrix game.
//  - Holds the bird's row as a one-hot 8-bit column that drives matrix column 3.
//  - Applies periodic gravity and accepts one-cycle flap pulses.
//  - Raises a sticky game-over on ground hit or an external pipe crash.
//  - Sits between the debounced flap input and the matrix/pipe/score logic.

---
 rtl/control_bird_movement.sv | 106 ++++++++++
 tb/tb_control_bird_movement.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/control_bird_movement.sv
// Vertical motion controller for the bird on the 8x8 LED matrix: gravity, flaps, sticky game-over.
// Optional: define CEILING_CRASH_EN to make a flap at the top row end the game.
module control_bird_movement #(
   parameter int FALL_TICKS = 12_500_000,
   parameter int START_ROW  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       flap,
   input  logic       crash,
   output logic [7:0] bird,
   output logic       game_over
);

   localparam int              CW         = $clog2(FALL_TICKS);
   localparam logic [CW-1:0]   LAST_COUNT = CW'(FALL_TICKS - 1);
   localparam logic [7:0]      START_BIRD = 8'b1 << START_ROW;

   typedef enum logic [0:0] {
      ST_PLAY,
      ST_OVER
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [7:0]    bird_q;
   logic [7:0]    bird_next;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_next;
   logic          tick;
   logic          at_top;
   logic          at_ground;

   assign tick      = (count_q == LAST_COUNT);
   assign at_top    = bird_q[7];
   assign at_ground = bird_q[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_PLAY;
      end else begin
         state <= state_next;
      end
   end

   // Crash outranks flap, flap outranks gravity; start=0 parks the bird without ending play.
   always_comb begin
      state_next = state;
      if (state == ST_PLAY && start) begin
         if (crash) begin
            state_next = ST_OVER;
         end else if (flap) begin
`ifdef CEILING_CRASH_EN
            if (at_top) begin
               state_next = ST_OVER;
            end
`endif
         end else if (tick && at_ground) begin
            state_next = ST_OVER;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bird_q  <= START_BIRD;
         count_q <= '0;
      end else begin
         bird_q  <= bird_next;
         count_q <= count_next;
      end
   end

   // Shifts saturate at bit 7 / bit 0 so the column stays one-hot.
   always_comb begin
      bird_next  = bird_q;
      count_next = count_q;
      if (state == ST_PLAY) begin
         if (!start) begin
            bird_next  = START_BIRD;
            count_next = '0;
         end else if (crash) begin
            bird_next  = bird_q;
         end else if (flap) begin
            count_next = '0;
            if (!at_top) begin
               bird_next = bird_q << 1;
            end
         end else if (tick) begin
            count_next = '0;
            if (!at_ground) begin
               bird_next = bird_q >> 1;
            end
         end else begin
            count_next = count_q + 1'b1;
         end
      end
   end

   always_comb begin
      bird      = bird_q;
      game_over = (state == ST_OVER);
   end

endmodule

// File: tb/tb_control_bird_movement.sv
// Scoreboard bench for control_bird_movement with FALL_TICKS=4, START_ROW=4.
module tb_control_bird_movement;

   logic       clk;
   logic       reset;
   logic       start;
   logic       flap;
   logic       crash;
   logic [7:0] bird;
   logic       game_over;

`ifdef CEILING_CRASH_EN
   localparam bit CEIL_EN = 1'b1;
`else
   localparam bit CEIL_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] bird;
      logic       go;
      int         step;
   } exp_t;

   exp_t sb_q[$];
   int   step_id  = 0;
   int   checks   = 0;
   int   failures = 0;

   control_bird_movement #(
      .FALL_TICKS(4),
      .START_ROW (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .flap     (flap),
      .crash    (crash),
      .bird     (bird),
      .game_over(game_over)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push_expect(input logic [7:0] eb, input logic eg);
      exp_t e;
      step_id++;
      e.bird = eb;
      e.go   = eg;
      e.step = step_id;
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs, then record the state expected after that edge.
   task automatic apply_stimulus(input logic st, input logic fl, input logic cr,
                                 input logic [7:0] eb, input logic eg);
      start = st;
      flap  = fl;
      crash = cr;
      @(posedge clk);
      #1;
      flap  = 1'b0;
      crash = 1'b0;
      push_expect(eb, eg);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      start = 1'b0;
      flap  = 1'b0;
      crash = 1'b0;
      #1;
      push_expect(8'h10, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_output(input exp_t e);
      checks++;
      if (bird !== e.bird) begin
         failures++;
         $display("[TB] FAIL bird step %0d: got %h, expected %h", e.step, bird, e.bird);
      end
      checks++;
      if (game_over !== e.go) begin
         failures++;
         $display("[TB] FAIL game_over step %0d: got %b, expected %b", e.step, game_over, e.go);
      end
      checks++;
      if (!$onehot(bird)) begin
         failures++;
         $display("[TB] FAIL onehot step %0d: got %b, expected exactly one bit set", e.step, bird);
      end
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         check_output(sb_q.pop_front());
      end
   end

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      logic [7:0] eb;
      reset = 1'b1;
      start = 1'b0;
      flap  = 1'b0;
      crash = 1'b0;

      $display("[TB] gravity fall to ground");
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         eb = 8'h10;
         eb = (k <= 16) ? (eb >> (k / 4)) : 8'h01;
         apply_stimulus(1'b1, (k > 20), 1'b0, eb, (k >= 20));
      end

      $display("[TB] reset from game over, then climb to ceiling");
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         eb = 8'h10;
         eb = (i <= 3) ? (eb << i) : 8'h80;
         apply_stimulus(1'b1, 1'b1, 1'b0, eb, CEIL_EN && (i >= 4));
         apply_stimulus(1'b1, 1'b0, 1'b0, eb, CEIL_EN && (i >= 4));
      end

      $display("[TB] flap restarts counter, flap beats tick");
      do_reset();
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);

      $display("[TB] crash freezes bird");
      do_reset();
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h08, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b1, 8'h08, 1'b1);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 8'h08, 1'b1);
      for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h08, 1'b1);

      $display("[TB] crash beats flap and tick");
      do_reset();
      apply_stimulus(1'b1, 1'b1, 1'b1, 8'h10, 1'b1);
      do_reset();
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b1, 8'h10, 1'b1);

      $display("[TB] start low parks bird");
      do_reset();
      for (int k = 1; k <= 20; k++) apply_stimulus(1'b0, k[0], 1'b0, 8'h10, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'h08, 1'b0);

      repeat (2) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
